// File: rtl/pe_mac_buf.sv
// Output-stationary systolic MAC PE: forwards A/B east/south, accumulates dot products,
// and queues finished results in a small drain FIFO. Define PE_SAT_EN for saturating adds.
module pe_mac_buf #(
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned ACC_WIDTH   = 32,
  parameter int unsigned DRAIN_DEPTH = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  clear_i,
  input  logic                  mode_i,
  input  logic                  a_valid_i,
  input  logic [DATA_WIDTH-1:0] a_data_i,
  input  logic                  a_last_i,
  input  logic                  b_valid_i,
  input  logic [DATA_WIDTH-1:0] b_data_i,
  input  logic                  b_last_i,
  output logic                  a_valid_o,
  output logic [DATA_WIDTH-1:0] a_data_o,
  output logic                  a_last_o,
  output logic                  b_valid_o,
  output logic [DATA_WIDTH-1:0] b_data_o,
  output logic                  b_last_o,
  output logic                  drain_valid_o,
  output logic [ACC_WIDTH-1:0]  drain_data_o,
  output logic                  drain_sat_o,
  input  logic                  drain_ready_i,
  output logic                  err_proto_o,
  output logic                  err_ovf_o
);

  localparam int unsigned PROD_WIDTH = 2 * DATA_WIDTH;
  localparam int unsigned PTR_WIDTH  = $clog2(DRAIN_DEPTH);
  localparam int unsigned CNT_WIDTH  = PTR_WIDTH + 1;

  logic [ACC_WIDTH-1:0]  acc_q;
  logic                  start_q;
  logic                  mode_q;
  logic                  sat_q;

  logic [ACC_WIDTH-1:0]  fifo_data [DRAIN_DEPTH];
  logic                  fifo_sat  [DRAIN_DEPTH];
  logic [PTR_WIDTH-1:0]  wr_ptr_q;
  logic [PTR_WIDTH-1:0]  rd_ptr_q;
  logic [CNT_WIDTH-1:0]  count_q;

  logic                  beat;
  logic                  last_beat;
  logic                  proto_err;
  logic                  mode_use;
  logic [PROD_WIDTH-1:0] a_ext;
  logic [PROD_WIDTH-1:0] b_ext;
  logic [PROD_WIDTH-1:0] prod;
  logic [ACC_WIDTH-1:0]  prod_ext;
  logic [ACC_WIDTH-1:0]  base;
  logic [ACC_WIDTH-1:0]  acc_n;
  logic                  clamp;
  logic                  sat_n;
  logic                  pop;
  logic                  full;
  logic                  push_ok;
  logic                  drop;
  logic [PTR_WIDTH-1:0]  rd_ptr_n;
  logic [CNT_WIDTH-1:0]  count_n;
  logic [ACC_WIDTH-1:0]  head_data;
  logic                  head_sat;
`ifdef PE_SAT_EN
  logic [ACC_WIDTH:0]    sum_full;
`endif

  // Beat qualification, product and next accumulator value
  always_comb begin
    beat      = a_valid_i && b_valid_i;
    last_beat = beat && a_last_i && b_last_i;
    proto_err = (a_valid_i != b_valid_i) || (beat && (a_last_i != b_last_i));
    mode_use  = start_q ? mode_i : mode_q;
    a_ext     = {{DATA_WIDTH{mode_use & a_data_i[DATA_WIDTH-1]}}, a_data_i};
    b_ext     = {{DATA_WIDTH{mode_use & b_data_i[DATA_WIDTH-1]}}, b_data_i};
    prod      = a_ext * b_ext;
    prod_ext  = ACC_WIDTH'(prod);
    if (mode_use && prod[PROD_WIDTH-1]) begin
      prod_ext = prod_ext | ~ACC_WIDTH'({PROD_WIDTH{1'b1}});
    end
    base  = start_q ? '0 : acc_q;
    clamp = 1'b0;
`ifdef PE_SAT_EN
    sum_full = {1'b0, base} + {1'b0, prod_ext};
    acc_n    = sum_full[ACC_WIDTH-1:0];
    if (mode_use) begin
      // signed overflow: operands agree in sign, sum does not
      if ((base[ACC_WIDTH-1] == prod_ext[ACC_WIDTH-1]) &&
          (acc_n[ACC_WIDTH-1] != base[ACC_WIDTH-1])) begin
        clamp = 1'b1;
        acc_n = base[ACC_WIDTH-1] ? {1'b1, {(ACC_WIDTH-1){1'b0}}}
                                  : {1'b0, {(ACC_WIDTH-1){1'b1}}};
      end
    end else if (sum_full[ACC_WIDTH]) begin
      clamp = 1'b1;
      acc_n = '1;
    end
`else
    acc_n = base + prod_ext;
`endif
    sat_n = (start_q ? 1'b0 : sat_q) | clamp;
  end

  // FIFO bookkeeping and the head value presented after this edge
  always_comb begin
    pop      = drain_valid_o && drain_ready_i;
    full     = (count_q == CNT_WIDTH'(DRAIN_DEPTH));
    push_ok  = last_beat && (!full || pop);
    drop     = last_beat && full && !pop;
    rd_ptr_n = pop ? (rd_ptr_q + PTR_WIDTH'(1)) : rd_ptr_q;
    count_n  = count_q + CNT_WIDTH'(push_ok) - CNT_WIDTH'(pop);
    if (push_ok && (wr_ptr_q == rd_ptr_n)) begin
      head_data = acc_n;
      head_sat  = sat_n;
    end else begin
      head_data = fifo_data[rd_ptr_n];
      head_sat  = fifo_sat[rd_ptr_n];
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      a_valid_o <= 1'b0;
      a_last_o  <= 1'b0;
      a_data_o  <= '0;
      b_valid_o <= 1'b0;
      b_last_o  <= 1'b0;
      b_data_o  <= '0;
    end else if (clear_i) begin
      a_valid_o <= 1'b0;
      a_last_o  <= 1'b0;
      a_data_o  <= '0;
      b_valid_o <= 1'b0;
      b_last_o  <= 1'b0;
      b_data_o  <= '0;
    end else begin
      a_valid_o <= a_valid_i;
      a_last_o  <= a_last_i;
      b_valid_o <= b_valid_i;
      b_last_o  <= b_last_i;
      if (a_valid_i) a_data_o <= a_data_i;
      if (b_valid_i) b_data_o <= b_data_i;
    end
  end

  // Accumulator; a last beat restarts the next dot product with no bubble
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      acc_q   <= '0;
      start_q <= 1'b1;
      mode_q  <= 1'b0;
      sat_q   <= 1'b0;
    end else if (clear_i) begin
      acc_q   <= '0;
      start_q <= 1'b1;
      sat_q   <= 1'b0;
    end else if (beat) begin
      acc_q <= acc_n;
      if (start_q) mode_q <= mode_i;
      if (last_beat) begin
        start_q <= 1'b1;
        sat_q   <= 1'b0;
      end else begin
        start_q <= 1'b0;
        sat_q   <= sat_n;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      err_proto_o <= 1'b0;
      err_ovf_o   <= 1'b0;
    end else if (clear_i) begin
      err_proto_o <= 1'b0;
      err_ovf_o   <= 1'b0;
    end else begin
      if (proto_err) err_proto_o <= 1'b1;
      if (drop)      err_ovf_o   <= 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok && !clear_i) begin
      fifo_data[wr_ptr_q] <= acc_n;
      fifo_sat[wr_ptr_q]  <= sat_n;
    end
  end

  // Head registers hold steady while stalled; they only reload when the FIFO is non-empty
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      drain_valid_o <= 1'b0;
      drain_data_o  <= '0;
      drain_sat_o   <= 1'b0;
    end else if (clear_i) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      drain_valid_o <= 1'b0;
      drain_data_o  <= '0;
      drain_sat_o   <= 1'b0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + PTR_WIDTH'(1);
      rd_ptr_q      <= rd_ptr_n;
      count_q       <= count_n;
      drain_valid_o <= (count_n != '0);
      if (count_n != '0) begin
        drain_data_o <= head_data;
        drain_sat_o  <= head_sat;
      end
    end
  end

endmodule

// File: tb/tb_pe_mac_buf.sv
// Scoreboard bench for pe_mac_buf: a 32-bit and a 16-bit accumulator instance share stimulus.
module tb_pe_mac_buf;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, clear, mode, drain_ready;
  logic       a_valid, b_valid, a_last, b_last;
  logic [7:0] a_data, b_data;

  logic        f_a_valid, f_a_last, f_b_valid, f_b_last;
  logic [7:0]  f_a_data, f_b_data;
  logic        d_valid, d_sat, e_proto, e_ovf;
  logic [31:0] d_data;

  logic        g_a_valid, g_a_last, g_b_valid, g_b_last;
  logic [7:0]  g_a_data, g_b_data;
  logic        h_valid, h_sat, h_proto, h_ovf;
  logic [15:0] h_data;

  pe_mac_buf #(.DATA_WIDTH(8), .ACC_WIDTH(32), .DRAIN_DEPTH(2)) dut (
    .clk_i(clk), .rst_i(rst), .clear_i(clear), .mode_i(mode),
    .a_valid_i(a_valid), .a_data_i(a_data), .a_last_i(a_last),
    .b_valid_i(b_valid), .b_data_i(b_data), .b_last_i(b_last),
    .a_valid_o(f_a_valid), .a_data_o(f_a_data), .a_last_o(f_a_last),
    .b_valid_o(f_b_valid), .b_data_o(f_b_data), .b_last_o(f_b_last),
    .drain_valid_o(d_valid), .drain_data_o(d_data), .drain_sat_o(d_sat),
    .drain_ready_i(drain_ready), .err_proto_o(e_proto), .err_ovf_o(e_ovf));

  pe_mac_buf #(.DATA_WIDTH(8), .ACC_WIDTH(16), .DRAIN_DEPTH(2)) dut16 (
    .clk_i(clk), .rst_i(rst), .clear_i(clear), .mode_i(mode),
    .a_valid_i(a_valid), .a_data_i(a_data), .a_last_i(a_last),
    .b_valid_i(b_valid), .b_data_i(b_data), .b_last_i(b_last),
    .a_valid_o(g_a_valid), .a_data_o(g_a_data), .a_last_o(g_a_last),
    .b_valid_o(g_b_valid), .b_data_o(g_b_data), .b_last_o(g_b_last),
    .drain_valid_o(h_valid), .drain_data_o(h_data), .drain_sat_o(h_sat),
    .drain_ready_i(drain_ready), .err_proto_o(h_proto), .err_ovf_o(h_ovf));

  typedef struct {
    logic [31:0] d32;
    logic        s32;
    logic [15:0] d16;
    logic        s16;
    int          cyc;
  } exp_t;

  exp_t q32[$];
  exp_t q16[$];
  exp_t e32, e16;
  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitors: compare every accepted result against the head of its queue
  always @(negedge clk) begin
    if (!rst && d_valid && drain_ready) begin
      if (q32.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL acc32_unexpected: got %0h expected no result", d_data);
      end else begin
        e32 = q32.pop_front();
        chk("acc32_data", d_data, e32.d32);
        chk("acc32_sat", 32'(d_sat), 32'(e32.s32));
        if (e32.cyc >= 0) chk("acc32_latency", 32'(cyc), 32'(e32.cyc));
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && h_valid && drain_ready) begin
      if (q16.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL acc16_unexpected: got %0h expected no result", h_data);
      end else begin
        e16 = q16.pop_front();
        chk("acc16_data", 32'(h_data), 32'(e16.d16));
        chk("acc16_sat", 32'(h_sat), 32'(e16.s16));
        if (e16.cyc >= 0) chk("acc16_latency", 32'(cyc), 32'(e16.cyc));
      end
    end
  end

  task automatic drive(input logic av, input logic bv, input logic [7:0] a, input logic [7:0] b,
                       input logic al, input logic bl);
    a_valid = av; b_valid = bv; a_data = a; b_data = b; a_last = al; b_last = bl;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 1'b0, 8'd0, 8'd0, 1'b0, 1'b0);
  endtask

  task automatic expect_res(input logic [31:0] d32, input logic s32, input logic [15:0] d16,
                            input logic s16, input int c);
    exp_t e;
    e.d32 = d32; e.s32 = s32; e.d16 = d16; e.s16 = s16; e.cyc = c;
    q32.push_back(e);
    q16.push_back(e);
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((q32.size() != 0 || q16.size() != 0) && n < 20) begin
      idle(1);
      n++;
    end
    chk("drain_timeout", 32'(q32.size() + q16.size()), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; clear = 1'b0; mode = 1'b0; drain_ready = 1'b0;
    a_valid = 1'b0; b_valid = 1'b0; a_last = 1'b0; b_last = 1'b0; a_data = 8'd0; b_data = 8'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_drain_valid", 32'(d_valid), 32'd0);
    chk("reset_drain_data", d_data, 32'd0);
    chk("reset_fwd_valid", 32'(f_a_valid), 32'd0);
    chk("reset_fwd_data", 32'(f_b_data), 32'd0);
    chk("reset_err", 32'({e_proto, e_ovf}), 32'd0);
    chk("reset_drain16_valid", 32'(h_valid), 32'd0);
    rst = 1'b0;
    drain_ready = 1'b1;

    // Unsigned dot product 3*4 + 5*6 + 7*8 = 98, with forwarding checks
    drive(1'b1, 1'b1, 8'd3, 8'd4, 1'b0, 1'b0);
    chk("fwd_a_valid", 32'(f_a_valid), 32'd1);
    chk("fwd_a_data", 32'(f_a_data), 32'd3);
    chk("fwd_b_data", 32'(f_b_data), 32'd4);
    drive(1'b1, 1'b1, 8'd5, 8'd6, 1'b0, 1'b0);
    chk("fwd_a_data2", 32'(f_a_data), 32'd5);
    chk("fwd_b_data2", 32'(f_b_data), 32'd6);
    expect_res(32'd98, 1'b0, 16'd98, 1'b0, cyc + 1);
    drive(1'b1, 1'b1, 8'd7, 8'd8, 1'b1, 1'b1);
    chk("fwd_last", 32'({f_a_last, f_b_last}), 32'd3);
    idle(1);
    chk("fwd_valid_drop", 32'({f_a_valid, f_b_valid}), 32'd0);
    chk("fwd_data_hold", 32'(f_a_data), 32'd7);
    wait_drain();

    // Signed back-to-back: (-128*-128) then (-1*5)
    mode = 1'b1;
    expect_res(32'd16384, 1'b0, 16'd16384, 1'b0, cyc + 1);
    drive(1'b1, 1'b1, 8'h80, 8'h80, 1'b1, 1'b1);
    expect_res(32'hFFFF_FFFB, 1'b0, 16'hFFFB, 1'b0, cyc + 1);
    drive(1'b1, 1'b1, 8'hFF, 8'h05, 1'b1, 1'b1);
    mode = 1'b0;
    wait_drain();

    // Stalled drain: third result dropped on a full FIFO
    drain_ready = 1'b0;
    expect_res(32'd1, 1'b0, 16'd1, 1'b0, -1);
    drive(1'b1, 1'b1, 8'd1, 8'd1, 1'b1, 1'b1);
    expect_res(32'd4, 1'b0, 16'd4, 1'b0, -1);
    drive(1'b1, 1'b1, 8'd2, 8'd2, 1'b1, 1'b1);
    drive(1'b1, 1'b1, 8'd3, 8'd3, 1'b1, 1'b1);
    idle(1);
    chk("ovf_err32", 32'(e_ovf), 32'd1);
    chk("ovf_err16", 32'(h_ovf), 32'd1);
    chk("stall_valid", 32'(d_valid), 32'd1);
    chk("stall_head", d_data, 32'd1);
    idle(1);
    chk("stall_head_stable", d_data, 32'd1);
    drain_ready = 1'b1;
    wait_drain();
    expect_res(32'd25, 1'b0, 16'd25, 1'b0, cyc + 1);
    drive(1'b1, 1'b1, 8'd5, 8'd5, 1'b1, 1'b1);
    wait_drain();

    // Clear, then protocol error from a lone A operand
    clear = 1'b1;
    idle(1);
    clear = 1'b0;
    chk("clear_err_ovf", 32'(e_ovf), 32'd0);
    drive(1'b1, 1'b1, 8'd2, 8'd3, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 8'd9, 8'd9, 1'b0, 1'b0);
    chk("proto_err_set", 32'(e_proto), 32'd1);
    chk("proto_fwd_valid", 32'({f_a_valid, f_b_valid}), 32'd2);
    chk("proto_fwd_b_hold", 32'(f_b_data), 32'd3);
    expect_res(32'd7, 1'b0, 16'd7, 1'b0, cyc + 1);
    drive(1'b1, 1'b1, 8'd1, 8'd1, 1'b1, 1'b1);
    wait_drain();
    chk("proto_err_sticky", 32'(e_proto), 32'd1);
    clear = 1'b1;
    idle(1);
    clear = 1'b0;
    chk("clear_err_proto", 32'(e_proto), 32'd0);
    chk("clear_fwd_valid", 32'(f_a_valid), 32'd0);

    // Signed 127*127 three times: exceeds a 16-bit accumulator
    mode = 1'b1;
    drive(1'b1, 1'b1, 8'd127, 8'd127, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 8'd127, 8'd127, 1'b0, 1'b0);
`ifdef PE_SAT_EN
    expect_res(32'd48387, 1'b0, 16'h7FFF, 1'b1, cyc + 1);
`else
    expect_res(32'd48387, 1'b0, 16'd48387, 1'b0, cyc + 1);
`endif
    drive(1'b1, 1'b1, 8'd127, 8'd127, 1'b1, 1'b1);
    mode = 1'b0;
    wait_drain();

    // Asynchronous reset mid dot product with one result queued
    drain_ready = 1'b0;
    drive(1'b1, 1'b1, 8'd4, 8'd4, 1'b1, 1'b1);
    drive(1'b1, 1'b1, 8'd1, 8'd1, 1'b0, 1'b0);
    chk("pre_reset_queued", 32'(d_valid), 32'd1);
    a_valid = 1'b0; b_valid = 1'b0; a_last = 1'b0; b_last = 1'b0;
    #1;
    rst = 1'b1;
    #1;
    chk("async_rst_drain_valid", 32'(d_valid), 32'd0);
    chk("async_rst_drain_data", d_data, 32'd0);
    chk("async_rst_fwd", 32'({f_a_valid, f_b_valid, f_a_last, f_b_last}), 32'd0);
    chk("async_rst_fwd_data", 32'(f_a_data), 32'd0);
    chk("async_rst_drain16", 32'(h_valid), 32'd0);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    drain_ready = 1'b1;
    expect_res(32'd4, 1'b0, 16'd4, 1'b0, cyc + 1);
    drive(1'b1, 1'b1, 8'd2, 8'd2, 1'b1, 1'b1);
    wait_drain();
    idle(2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pe_mac_buf.md
# pe_mac_buf

Parametrised output-stationary processing element for the systolic matrix-multiply array: the next generation of the basic MAC PE. It forwards A/B operands to its east/south neighbours with one cycle of delay. It accumulates signed or unsigned dot products in a configurable-width accumulator and queues finished results in a small drain FIFO with a valid/ready handshake, so a slow drain does not block the next accumulation. Protocol and overflow faults are reported through sticky error flags.

## Interface
- DATA_WIDTH, 8: operand width (bits).
- ACC_WIDTH, 32: accumulator and result width; must be ≥ 2*DATA_WIDTH.
- DRAIN_DEPTH, 2: drain FIFO entries; power of two, ≥ 2.
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  reset; asynchronous, active-high.
- clear_i  in  1  synchronous clear of accumulator, FIFO, errors and forward registers.
- mode_i  in  1  0 = unsigned, 1 = signed; sampled on the first beat of each dot product.
- a_valid_i, b_valid_i  in  1  operand beat valid.
- a_data_i, b_data_i  in  DATA_WIDTH  operands.
- a_last_i, b_last_i  in  1  final beat of a dot product.
- a_valid_o, a_data_o, a_last_o  out  1/DATA_WIDTH/1  registered A forward.
- b_valid_o, b_data_o, b_last_o  out  1/DATA_WIDTH/1  registered B forward.
- drain_valid_o  out  1  FIFO not empty.
- drain_data_o  out  ACC_WIDTH  FIFO head result.
- drain_sat_o  out  1  head result saturated.
- drain_ready_i  in  1  consumer accepts head.
- err_proto_o  out  1  sticky: valid mismatch seen.
- err_ovf_o  out  1  sticky: result dropped on full FIFO.

## Operation
- Forward path:
  - *_valid_o and *_last_o are registered every cycle from the inputs.
  - *_data_o loads only when the matching *_valid_i is high; otherwise it holds.
- Beat: a_valid_i && b_valid_i.
- Accumulation:
  - State: acc_q, start_q (reset 1), mode_q, sat_q.
  - On a beat, prod = a*b at 2*DATA_WIDTH, computed in signed or unsigned interpretation.
  - prod is sign- or zero-extended to ACC_WIDTH.
  - acc_n = (start_q ? 0 : acc_q) + prod_ext.
  - On a beat with start_q = 1, mode_q <= mode_i and the current beat uses mode_i; later beats use mode_q.
- Last beat: a beat with a_last_i && b_last_i.
  - acc_n is pushed to the FIFO with its sat flag.
  - start_q <= 1 and sat_q clears.
  - Non-last beat: start_q <= 0.
- Protocol error:
  - a_valid_i != b_valid_i sets err_proto_o.
  - The lone operand is not accumulated; forwarding is unaffected.
  - a_last_i != b_last_i on a beat also sets err_proto_o; the beat is treated as non-last.
  - last asserted without valid is ignored.
- FIFO:
  - Push on last beat; pop on drain_valid_o && drain_ready_i.
  - Full with simultaneous pop: the push is accepted.
  - Full without pop: the result is dropped, err_ovf_o is set, and the accumulator still restarts.
  - Empty with pop: not possible, because drain_valid_o = 0.
  - Pointers wrap modulo DRAIN_DEPTH; count is held in log2(DRAIN_DEPTH)+1 bits.
- clear_i: empties the FIFO, sets start_q = 1, clears both errors and all forward valids; it overrides a same-cycle beat or pop.

## Timing
- Reset values:
  - All *_valid_o, *_last_o, drain_valid_o, drain_sat_o and err_* are 0.
  - *_data_o and drain_data_o are 0.
  - acc_q = 0, start_q = 1.
- Forward latency: 1 cycle.
- Result latency: the last beat at edge N makes drain_valid_o = 1 in cycle N+1.
- Back-to-back: a new dot product may begin on the beat immediately after a last beat, with no bubble.
- Throughput: one beat per cycle, sustained indefinitely while the FIFO is drained.
- drain_data_o and drain_sat_o remain stable while drain_valid_o && !drain_ready_i.
- Reset asserted mid-operation: all state returns to reset values immediately (asynchronous); any in-progress sum and queued results are lost.

## Configuration
- PE_SAT_EN defined:
  - Each addition saturates: signed to [-2^(ACC_WIDTH-1), 2^(ACC_WIDTH-1)-1], unsigned to [0, 2^ACC_WIDTH-1].
  - Any clamped addition within a dot product sets sat_q, which is reported as drain_sat_o for that result.
- PE_SAT_EN undefined: additions wrap modulo 2^ACC_WIDTH, and drain_sat_o is tied to 0.

## Test plan
- Reset, then unsigned beats (3,4), (5,6), (7,8)-last with drain_ready_i = 1 -> drain_data_o = 98 one cycle after the last beat; the forward outputs reproduce each beat one cycle later.
- Signed mode, DATA_WIDTH = 8, beats (-128,-128)-last then (-1,5)-last back-to-back -> results 16384 and -5 on consecutive cycles, with no bubble.
- drain_ready_i = 0 with DRAIN_DEPTH = 2, three single-beat dot products (1,1), (2,2), (3,3) -> FIFO holds 1 and 4, err_ovf_o = 1, and the third result is dropped; the next dot product still starts from 0.
- a_valid_i = 1 with b_valid_i = 0 for one cycle, within the sequence (2,3), (9,9)-A-only, (1,1)-last -> result 7, err_proto_o = 1; clear_i then resets err_proto_o to 0.
- ACC_WIDTH = 16, signed beats (127,127) repeated 3 times with the last on beat 3 -> with PE_SAT_EN: 32767 and drain_sat_o = 1; without it: 48387 mod 2^16 = -17149.
- rst_i asserted asynchronously mid-dot-product with 1 result queued -> all outputs are 0 before the next edge; after release, (2,2)-last yields 4.
